// File: rtl/vx_tl_pkg.sv
// Shared TileLink-UL definitions for the Vortex memory responder.
// Holds the A/D opcode encodings, data/mask widths and the packed D-channel
// response record carried through the responder's delay pipe and queue.
package vx_tl_pkg;

    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_GET             = 3'd4;
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    localparam int unsigned TL_DATA_W = 128;
    localparam int unsigned TL_MASK_W = 16;
    // The record carries the tag at a fixed maximum width so that one struct
    // type serves every SOURCE_W; the top zero-extends and truncates.
    localparam int unsigned TL_SOURCE_MAX_W = 32;

    typedef struct packed {
        logic [2:0]                 opcode;
        logic [3:0]                 size;
        logic [TL_SOURCE_MAX_W-1:0] source;
        logic                       denied;
        logic [TL_DATA_W-1:0]       data;
        logic                       corrupt;
    } tl_d_rsp_t;

    function automatic logic tl_opcode_supported(input logic [2:0] op);
        return (op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL) || (op == TL_GET);
    endfunction

endpackage

// File: rtl/vx_tl_rsp_queue.sv
// Synchronous FIFO of D-channel response records.
// Ports:
//   clock, reset           - clock, synchronous active-high reset (empties queue)
//   in_valid/in_ready      - push handshake, in_data is the record to store
//   out_valid/out_ready    - pop handshake, out_data is the head record
// The head record stays stable until it is popped.
module vx_tl_rsp_queue
    import vx_tl_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      in_valid,
    output logic      in_ready,
    input  tl_d_rsp_t in_data,
    output logic      out_valid,
    input  logic      out_ready,
    output tl_d_rsp_t out_data
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    tl_d_rsp_t          store_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic               push;
    logic               pop;

    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_data  = store_q[rd_ptr_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clock) begin
        if (push) begin
            store_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vx_tl_mem_responder.sv
// TileLink-UL manager backing memory for the Vortex 128-bit memory port.
// Accepts single-beat Get / PutFullData / PutPartialData on channel A,
// performs them on an internal word array and answers on channel D after
// LATENCY cycles, in accept order.
// Ports:
//   clock, reset        - clock, synchronous active-high reset
//   a_*                 - A channel (request), a_ready gated by outstanding credit
//   d_*                 - D channel (response), held stable until d_ready
// Memory contents survive reset; in-flight responses do not.
module vx_tl_mem_responder
    import vx_tl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned LATENCY   = 2,
    parameter int unsigned RSP_DEPTH = 4,
    parameter int unsigned SOURCE_W  = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 a_ready,
    input  logic                 a_valid,
    input  logic [2:0]           a_bits_opcode,
    input  logic [2:0]           a_bits_param,
    input  logic [3:0]           a_bits_size,
    input  logic [SOURCE_W-1:0]  a_bits_source,
    input  logic [31:0]          a_bits_address,
    input  logic [15:0]          a_bits_mask,
    input  logic [127:0]         a_bits_data,
    input  logic                 a_bits_corrupt,
    input  logic                 d_ready,
    output logic                 d_valid,
    output logic [2:0]           d_bits_opcode,
    output logic [1:0]           d_bits_param,
    output logic [3:0]           d_bits_size,
    output logic [SOURCE_W-1:0]  d_bits_source,
    output logic [2:0]           d_bits_sink,
    output logic                 d_bits_denied,
    output logic [127:0]         d_bits_data,
    output logic                 d_bits_corrupt
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(RSP_DEPTH + 1);

    if (LATENCY < 1 || RSP_DEPTH < LATENCY || SOURCE_W > TL_SOURCE_MAX_W) begin : g_bad_params
        $error("vx_tl_mem_responder: illegal LATENCY/RSP_DEPTH/SOURCE_W combination");
    end

    logic [TL_DATA_W-1:0] mem_q [DEPTH];

    logic [OCC_W-1:0] occ_q;
    logic             accept;
    logic             d_fire;

    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic             bad_access;
    logic             is_get;
    logic             is_put;
    logic             write_en;
    tl_d_rsp_t        dec_rsp;

    logic             push_vld;
    tl_d_rsp_t        push_rsp;
    logic             q_in_ready;
    logic             q_out_valid;
    tl_d_rsp_t        q_head;
    tl_d_rsp_t        d_rsp;

    // ---------------------------------------------------------------- decode
    assign offset = a_bits_address - BASE_ADDR;
    assign idx    = offset[IDX_W+3:4];
    assign is_get = (a_bits_opcode == TL_GET);
    assign is_put = (a_bits_opcode == TL_PUT_FULL) || (a_bits_opcode == TL_PUT_PARTIAL);

    assign bad_access = (a_bits_address < BASE_ADDR)
                     || ((offset >> 4) >= DEPTH)
                     || (a_bits_address[3:0] != 4'h0)
                     || (a_bits_size != 4'd4)
                     || !tl_opcode_supported(a_bits_opcode);

    assign write_en = accept && is_put && !bad_access && !a_bits_corrupt;

    always_comb begin
        dec_rsp        = '0;
        dec_rsp.size   = a_bits_size;
        dec_rsp.source = TL_SOURCE_MAX_W'(a_bits_source);
        if (is_get) begin
            dec_rsp.opcode  = TL_ACCESS_ACK_DATA;
            dec_rsp.denied  = bad_access;
            dec_rsp.corrupt = bad_access;
            dec_rsp.data    = bad_access ? '0 : mem_q[idx];
        end else begin
            // Poisoned put data is refused rather than stored.
            dec_rsp.opcode = TL_ACCESS_ACK;
            dec_rsp.denied = bad_access || a_bits_corrupt;
        end
    end

    // ---------------------------------------------------------------- memory
    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int unsigned i = 0; i < TL_MASK_W; i++) begin
                if (a_bits_mask[i]) begin
                    mem_q[idx][i*8 +: 8] <= a_bits_data[i*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------ delay pipe
    // The queue register supplies the last cycle of latency, so the pipe
    // itself is LATENCY-1 stages and vanishes entirely for LATENCY == 1.
    if (LATENCY > 1) begin : g_pipe
        logic [LATENCY-2:0] vld_q;
        tl_d_rsp_t          stg_q [LATENCY-1];

        always_ff @(posedge clock) begin
            if (reset) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= accept;
                for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                    vld_q[i] <= vld_q[i-1];
                end
            end
        end

        always_ff @(posedge clock) begin
            stg_q[0] <= dec_rsp;
            for (int unsigned i = 1; i < LATENCY - 1; i++) begin
                stg_q[i] <= stg_q[i-1];
            end
        end

        assign push_vld = vld_q[LATENCY-2];
        assign push_rsp = stg_q[LATENCY-2];
    end else begin : g_no_pipe
        assign push_vld = accept;
        assign push_rsp = dec_rsp;
    end

    // ------------------------------------------------------- response queue
    // Credit accounting below guarantees the queue is never full on a push.
    vx_tl_rsp_queue #(
        .DEPTH (RSP_DEPTH)
    ) u_rsp_queue (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (push_vld),
        .in_ready  (q_in_ready),
        .in_data   (push_rsp),
        .out_valid (q_out_valid),
        .out_ready (d_ready),
        .out_data  (q_head)
    );

    // ----------------------------------------------------- occupancy credit
    assign a_ready = !reset && (occ_q < OCC_W'(RSP_DEPTH));
    assign accept  = a_valid && a_ready;
    assign d_fire  = d_valid && d_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            occ_q <= '0;
        end else if (accept && !d_fire) begin
            occ_q <= occ_q + 1'b1;
        end else if (d_fire && !accept) begin
            occ_q <= occ_q - 1'b1;
        end
    end

    // ------------------------------------------------------------ D outputs
    assign d_valid        = q_out_valid && !reset;
    assign d_rsp          = d_valid ? q_head : '0;
    assign d_bits_opcode  = d_rsp.opcode;
    assign d_bits_param   = '0;
    assign d_bits_size    = d_rsp.size;
    assign d_bits_source  = d_rsp.source[SOURCE_W-1:0];
    assign d_bits_sink    = '0;
    assign d_bits_denied  = d_rsp.denied;
    assign d_bits_data    = d_rsp.data;
    assign d_bits_corrupt = d_rsp.corrupt;

    logic unused_bits;
    assign unused_bits = ^{a_bits_param, offset, d_rsp, q_in_ready};

    // ------------------------------------------------------------ assertions
    always_ff @(posedge clock) begin
        if (!reset) begin
            a_no_fire_empty: assert (!(d_fire && (occ_q == '0)));
            a_occ_bound:     assert (occ_q <= OCC_W'(RSP_DEPTH));
        end
    end

endmodule

// File: tb/tb_vx_tl_mem_responder.sv
// Randomised scoreboard bench for vx_tl_mem_responder: a request driver
// pushes expected responses from a word-level reference model, and a D-channel
// monitor pops and compares them independently.
module tb_vx_tl_mem_responder;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned DEPTH = 4096;
    localparam int unsigned LAT   = 2;
    localparam int unsigned RD    = 4;
    localparam int unsigned SW    = 15;

    logic          clock = 1'b0;
    logic          reset;
    logic          a_ready, a_valid;
    logic [2:0]    a_bits_opcode, a_bits_param;
    logic [3:0]    a_bits_size;
    logic [SW-1:0] a_bits_source;
    logic [31:0]   a_bits_address;
    logic [15:0]   a_bits_mask;
    logic [127:0]  a_bits_data;
    logic          a_bits_corrupt;
    logic          d_ready, d_valid;
    logic [2:0]    d_bits_opcode;
    logic [1:0]    d_bits_param;
    logic [3:0]    d_bits_size;
    logic [SW-1:0] d_bits_source;
    logic [2:0]    d_bits_sink;
    logic          d_bits_denied;
    logic [127:0]  d_bits_data;
    logic          d_bits_corrupt;

    vx_tl_mem_responder #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .LATENCY   (LAT),
        .RSP_DEPTH (RD),
        .SOURCE_W  (SW)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .a_ready        (a_ready),
        .a_valid        (a_valid),
        .a_bits_opcode  (a_bits_opcode),
        .a_bits_param   (a_bits_param),
        .a_bits_size    (a_bits_size),
        .a_bits_source  (a_bits_source),
        .a_bits_address (a_bits_address),
        .a_bits_mask    (a_bits_mask),
        .a_bits_data    (a_bits_data),
        .a_bits_corrupt (a_bits_corrupt),
        .d_ready        (d_ready),
        .d_valid        (d_valid),
        .d_bits_opcode  (d_bits_opcode),
        .d_bits_param   (d_bits_param),
        .d_bits_size    (d_bits_size),
        .d_bits_source  (d_bits_source),
        .d_bits_sink    (d_bits_sink),
        .d_bits_denied  (d_bits_denied),
        .d_bits_data    (d_bits_data),
        .d_bits_corrupt (d_bits_corrupt)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [2:0]    op;
        logic [3:0]    size;
        logic [SW-1:0] src;
        logic          denied;
        logic [127:0]  data;
        logic          corrupt;
    } exp_t;

    exp_t         sb[$];
    logic [127:0] ref_mem [int unsigned];
    int           n_cmp = 0;
    int           n_err = 0;
    int           rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high
    int           last_fire_cyc = -1;
    int           st, ac, stall_sum;

    localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: TileLink access rules applied to a word-addressed dictionary.
    function automatic exp_t model(input logic [2:0] op, input logic [3:0] size,
                                   input logic [SW-1:0] src, input logic [31:0] addr,
                                   input logic [15:0] mask, input logic [127:0] data,
                                   input logic corrupt);
        exp_t        e;
        logic        ok;
        int unsigned word;
        logic [127:0] w;
        ok = (addr >= BASE) && (((addr - BASE) / 16) < DEPTH) && (addr % 16 == 0)
             && (size == 4) && (op == 0 || op == 1 || op == 4);
        word = (addr - BASE) / 16;
        e = '0;
        e.size = size;
        e.src  = src;
        if (op == 4) begin
            e.op      = 3'd1;
            e.denied  = !ok;
            e.corrupt = !ok;
            e.data    = ok ? ref_mem[word] : 128'h0;
        end else begin
            e.op     = 3'd0;
            e.denied = !ok || corrupt;
            if (!e.denied) begin
                w = ref_mem.exists(word) ? ref_mem[word] : 128'h0;
                for (int i = 0; i < 16; i++)
                    if (mask[i]) w[i*8 +: 8] = data[i*8 +: 8];
                ref_mem[word] = w;
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic issue(input logic [2:0] op, input logic [3:0] size, input logic [SW-1:0] src,
                         input logic [31:0] addr, input logic [15:0] mask, input logic [127:0] data,
                         input logic corrupt, output int stalls, output int acc_cyc);
        a_valid = 1'b1; a_bits_opcode = op; a_bits_param = 3'($urandom_range(0, 7));
        a_bits_size = size; a_bits_source = src; a_bits_address = addr;
        a_bits_mask = mask; a_bits_data = data; a_bits_corrupt = corrupt;
        stalls = 0; acc_cyc = -1;
        while (!a_ready && stalls < 200) begin
            @(negedge clock);
            stalls++;
        end
        if (!a_ready) begin
            n_cmp++; n_err++;
            $display("FAIL accept_timeout: a_ready still 0 after %0d cycles, required 1", stalls);
            a_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        sb.push_back(model(op, size, src, addr, mask, data, corrupt));
        @(negedge clock);
        a_valid = 1'b0;
    endtask

    task automatic get(input logic [SW-1:0] src, input logic [31:0] addr);
        issue(3'd4, 4'd4, src, addr, 16'h0, 128'h0, 1'b0, st, ac);
    endtask

    task automatic put(input logic [2:0] op, input logic [SW-1:0] src, input logic [31:0] addr,
                       input logic [15:0] mask, input logic [127:0] data);
        issue(op, 4'd4, src, addr, mask, data, 1'b0, st, ac);
    endtask

    task automatic wait_drain();
        int k = 0;
        rdy_mode = 2;
        while ((sb.size() != 0 || d_valid) && k < 500) begin
            @(negedge clock);
            k++;
        end
        check("drain_left", 160'(sb.size()), 160'(0));
    endtask

    initial begin
        d_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (rdy_mode)
                1:       d_ready = 1'b0;
                2:       d_ready = 1'b1;
                default: d_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // D-channel monitor: scoreboard pop on fire, stability while stalled.
    logic [159:0] held;
    logic         hold = 1'b0;
    logic [159:0] act;
    exp_t         e;
    initial begin
        forever begin
            @(negedge clock);
            act = 160'({d_bits_opcode, d_bits_param, d_bits_size, d_bits_source,
                        d_bits_sink, d_bits_denied, d_bits_data, d_bits_corrupt});
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (hold) check("d_hold", {act[158:0], d_valid}, {held[158:0], 1'b1});
                if (d_valid && d_ready) begin
                    if (sb.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL d_unexpected: got response %h, required none", act);
                    end else begin
                        e = sb.pop_front();
                        check("d_rsp", act, 160'({e.op, 2'b00, e.size, e.src, 3'b000,
                                                  e.denied, e.data, e.corrupt}));
                        last_fire_cyc = cyc;
                    end
                    hold = 1'b0;
                end else if (d_valid) begin
                    hold = 1'b1;
                    held = act;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    initial begin
        reset = 1'b1; a_valid = 1'b0; a_bits_opcode = '0; a_bits_param = '0; a_bits_size = '0;
        a_bits_source = '0; a_bits_address = '0; a_bits_mask = '0; a_bits_data = '0;
        a_bits_corrupt = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_idle", 160'({a_ready, d_valid, d_bits_opcode, d_bits_size, d_bits_source,
                                  d_bits_denied, d_bits_data, d_bits_corrupt}), 160'(0));
        reset = 1'b0;
        @(negedge clock);

        // Give every pool word a known value.
        for (int k = 0; k < 8; k++)
            put(3'd0, SW'(k), BASE + 32'(k * 16), 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
        wait_drain();

        // Full write then read-back, checking minimum latency.
        put(3'd0, 15'd5, BASE + 32'h10, 16'hFFFF, PAT);
        stall_sum = ac;
        wait_drain();
        check("put_latency", 160'(last_fire_cyc), 160'(stall_sum + LAT));
        get(15'd6, BASE + 32'h10);
        stall_sum = ac;
        wait_drain();
        check("get_latency", 160'(last_fire_cyc), 160'(stall_sum + LAT));

        // Partial write of the low four bytes.
        put(3'd1, 15'd7, BASE + 32'h10, 16'h000F, {16{8'hAA}});
        get(15'd8, BASE + 32'h10);
        wait_drain();

        // Credit exhaustion: four accepted, fifth waits for d_ready.
        rdy_mode = 1;
        @(negedge clock);
        for (int s = 0; s < 4; s++) get(SW'(s), BASE + 32'(s * 16));
        check("a_ready_full", 160'(a_ready), 160'(0));
        fork
            get(15'd4, BASE + 32'h40);
            begin repeat (4) @(negedge clock); rdy_mode = 2; end
        join
        wait_drain();

        // Denied requests, then a legal access.
        get(15'd20, 32'h7FFF_FFF0);
        get(15'd21, BASE + 32'(DEPTH * 16));
        issue(3'd4, 4'd2, 15'd22, BASE, 16'h0, 128'h0, 1'b0, st, ac);
        get(15'd23, BASE + 32'h4);
        issue(3'd2, 4'd4, 15'd24, BASE, 16'hFFFF, PAT, 1'b0, st, ac);
        issue(3'd0, 4'd4, 15'd25, BASE + 32'h20, 16'hFFFF, ~PAT, 1'b1, st, ac);
        get(15'd26, BASE + 32'h20);
        get(15'd27, BASE + 32'h10);
        wait_drain();

        // Back-to-back write then read of the same word.
        put(3'd0, 15'd30, BASE + 32'h30, 16'hFFFF, ~PAT);
        get(15'd31, BASE + 32'h30);
        wait_drain();

        // Steady state at three outstanding: accept and D fire share cycles.
        rdy_mode = 1;
        @(negedge clock);
        get(15'd40, BASE);
        get(15'd41, BASE + 32'h10);
        rdy_mode = 2;
        get(15'd42, BASE + 32'h20);
        stall_sum = 0;
        for (int s = 0; s < 8; s++) begin
            get(SW'(50 + s), BASE + 32'((s % 8) * 16));
            stall_sum += st;
        end
        check("steady_stalls", 160'(stall_sum), 160'(0));
        wait_drain();

        // Reset with responses in flight.
        rdy_mode = 1;
        @(negedge clock);
        for (int s = 0; s < 3; s++) get(SW'(60 + s), BASE + 32'(s * 16));
        reset = 1'b1;
        sb.delete();
        @(negedge clock);
        check("reset_mid", 160'({a_ready, d_valid}), 160'(0));
        @(negedge clock);
        reset = 1'b0;
        rdy_mode = 2;
        for (int s = 0; s < 5; s++) begin
            @(negedge clock);
            check("post_reset_idle", 160'(d_valid), 160'(0));
        end
        get(15'd70, BASE + 32'h10);
        get(15'd71, BASE + 32'h30);
        wait_drain();

        // Randomised mix with random d_ready.
        rdy_mode = 0;
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [31:0] pa;
            r  = $urandom_range(0, 99);
            pa = BASE + 32'($urandom_range(0, 7) * 16);
            if (r < 40)
                get(SW'($urandom), pa);
            else if (r < 65)
                put(3'd0, SW'($urandom), pa, 16'hFFFF, {$urandom, $urandom, $urandom, $urandom});
            else if (r < 85)
                put(3'd1, SW'($urandom), pa, 16'($urandom), {$urandom, $urandom, $urandom, $urandom});
            else begin
                case ($urandom_range(0, 5))
                    0: get(SW'($urandom), BASE - 32'($urandom_range(1, 4) * 16));
                    1: get(SW'($urandom), BASE + 32'(DEPTH * 16) + 32'($urandom_range(0, 3) * 16));
                    2: get(SW'($urandom), pa + 32'($urandom_range(1, 15)));
                    3: issue(3'd4, 4'($urandom_range(0, 3)), SW'($urandom), pa, 16'h0, 128'h0, 1'b0, st, ac);
                    4: issue(3'($urandom_range(5, 7)), 4'd4, SW'($urandom), pa, 16'hFFFF,
                             {$urandom, $urandom, $urandom, $urandom}, 1'b0, st, ac);
                    default: issue(3'd1, 4'd4, SW'($urandom), pa, 16'hFFFF,
                                   {$urandom, $urandom, $urandom, $urandom}, 1'b1, st, ac);
                endcase
            end
            if ($urandom_range(0, 4) == 0) @(negedge clock);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
